// File: rtl/seat_req_ctrl.sv
// seat_req_ctrl: accepts one seat request at a time, checks it against the
// downstream seat table verdict, issues a single write or clear strobe, and
// reports completion. A free-running minute clock stamps every write.
module seat_req_ctrl #(
   parameter int NUM_SEATS     = 32,
   parameter int TICKS_PER_MIN = 60,
   parameter int LIMIT_MIN     = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_student_no,
   input  logic [4:0]  req_seat_no,
   input  logic [1:0]  req_action,
   input  logic        clear_req,
   input  logic        Do_Not_Seat,
   output logic        write_mem,
   output logic        rst_mem,
   output logic [31:0] Student_No_mem,
   output logic [10:0] Time_mem,
   output logic [1:0]  Seat_State_mem,
   output logic [4:0]  Seat_No_mem,
   output logic [10:0] limit_time,
   output logic        resp_valid,
   output logic [1:0]  resp_code
);

   localparam int          PW          = $clog2(TICKS_PER_MIN);
   localparam logic [PW-1:0] PRE_MAX   = PW'(TICKS_PER_MIN - 1);
   localparam logic [10:0] MIN_MAX     = 11'd1439;
   localparam logic [10:0] LIMIT_VAL   = 11'(LIMIT_MIN);
   localparam logic [31:0] NUM_SEATS_W = 32'(NUM_SEATS);

   localparam logic [1:0] CODE_OK  = 2'd0;
   localparam logic [1:0] CODE_OCC = 2'd1;
   localparam logic [1:0] CODE_BAD = 2'd2;
   localparam logic [1:0] ACT_SIT  = 2'd2;
   localparam logic [1:0] ACT_ILL  = 2'd3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      WRITE = 3'd2,
      RESP  = 3'd3,
      CLEAR = 3'd4
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [1:0]      resp_code_s;
   logic            latch_s;
   logic            bad_r;
   logic [PW-1:0]   pre_r;
   logic            tick_s;

   // A request is malformed if the action is illegal, the seat is outside
   // the table, or a sit is attempted without a student number.
   function automatic logic is_bad_req(input logic [31:0] student,
                                       input logic [4:0]  seat,
                                       input logic [1:0]  action);
      logic bad_s;
      bad_s = 1'b0;
      if (action == ACT_ILL) begin
         bad_s = 1'b1;
      end else if ({27'd0, seat} >= NUM_SEATS_W) begin
         bad_s = 1'b1;
      end else if ((student == 32'd0) && (action == ACT_SIT)) begin
         bad_s = 1'b1;
      end else begin
         bad_s = 1'b0;
      end
      return bad_s;
   endfunction

   assign tick_s = (pre_r == PRE_MAX);

   // Minute prescaler and minute-of-day counter; runs regardless of FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_r    <= '0;
         Time_mem <= 11'd0;
      end else if (tick_s) begin
         pre_r    <= '0;
         Time_mem <= (Time_mem == MIN_MAX) ? 11'd0 : (Time_mem + 11'd1);
      end else begin
         pre_r    <= pre_r + 1'b1;
      end
   end

   // Away-hold limit is a constant presented as a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         limit_time <= LIMIT_VAL;
      end else begin
         limit_time <= LIMIT_VAL;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; clear wins over a simultaneous request in IDLE.
   always_comb begin
      next_state_s = state_r;
      resp_code_s  = CODE_OK;
      latch_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (clear_req) begin
               next_state_s = CLEAR;
            end else if (req_valid) begin
               next_state_s = CHECK;
               latch_s      = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         CHECK: begin
            if (bad_r) begin
               next_state_s = RESP;
               resp_code_s  = CODE_BAD;
            end else if (Do_Not_Seat) begin
               next_state_s = RESP;
               resp_code_s  = CODE_OCC;
            end else begin
               next_state_s = WRITE;
            end
         end
         WRITE:   next_state_s = RESP;
         RESP:    next_state_s = IDLE;
         CLEAR:   next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Request fields are captured on acceptance and held for the table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Student_No_mem <= 32'd0;
         Seat_No_mem    <= 5'd0;
         Seat_State_mem <= 2'd0;
         bad_r          <= 1'b0;
      end else if (latch_s) begin
         Student_No_mem <= req_student_no;
         Seat_No_mem    <= req_seat_no;
         Seat_State_mem <= req_action;
         bad_r          <= is_bad_req(req_student_no, req_seat_no, req_action);
      end
   end

   // Strobes and handshake outputs are registered from the upcoming state so
   // they align exactly with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_mem  <= 1'b0;
         rst_mem    <= 1'b0;
         resp_valid <= 1'b0;
         resp_code  <= CODE_OK;
         req_ready  <= 1'b1;
      end else begin
         write_mem  <= (next_state_s == WRITE);
         rst_mem    <= (next_state_s == CLEAR);
         resp_valid <= (next_state_s == RESP) || (next_state_s == CLEAR);
         req_ready  <= (next_state_s == IDLE);
         if ((next_state_s == RESP) || (next_state_s == CLEAR)) begin
            resp_code <= resp_code_s;
         end
      end
   end

endmodule
